// File: rtl/instruction_loader_if.sv
// Byte-stream and BRAM write-port bundle for the instruction loader.
// The master side feeds bytes and owns the BRAM read data. The slave side,
// which is the loader, accepts bytes and drives the BRAM write port.
interface instruction_loader_if #(
  parameter int ADDRS   = 256,
  parameter int OP_SIZE = 8
);
  localparam int ADDR_SIZE = $clog2(ADDRS);

  logic [7:0]           byte_in;
  logic                 byte_valid_in;
  logic                 byte_ready_out;
  logic [ADDR_SIZE-1:0] bram_addr;
  logic                 bram_we;
  logic                 bram_regce;
  logic [OP_SIZE-1:0]   bram_din;
  logic [OP_SIZE-1:0]   bram_dout;

  modport master (
    output byte_in, byte_valid_in, bram_dout,
    input  byte_ready_out, bram_addr, bram_we, bram_regce, bram_din
  );

  modport slave (
    input  byte_in, byte_valid_in, bram_dout,
    output byte_ready_out, bram_addr, bram_we, bram_regce, bram_din
  );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: assembles little-endian byte streams into OP_SIZE-bit
// words and writes them into consecutive instruction BRAM addresses starting
// at 0. The word count is clamped to ADDRS, so the address never wraps.
// Optional feature: define INSTRUCTION_LOADER_CHECKSUM_EN to add checksum_out.
// checksum_out is the XOR of every word written in the current load.
module instruction_loader #(
  parameter int  ADDRS     = 256,
  parameter int  OP_SIZE   = 8,
  localparam int ADDR_SIZE = $clog2(ADDRS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [ADDR_SIZE:0]   count_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [ADDR_SIZE:0]   words_written_out,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  output logic [OP_SIZE-1:0]   checksum_out,
`endif
  instruction_loader_if.slave  bus
);

  localparam int BYTES = OP_SIZE / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = ADDR_SIZE + 1;

  localparam logic [CW-1:0]        CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0]        ADDRS_W  = CW'(ADDRS);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(32'd1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        ww_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [IDX_W-1:0]     byte_idx_r;
  logic [OP_SIZE-1:0]   word_r;
  logic                 ready_r;
  logic                 we_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 accept_s;
  logic                 last_byte_s;
  logic [CW-1:0]        ww_inc_s;
  logic [CW-1:0]        clamp_s;
  logic                 unused_s;

  // BRAM read data is not needed by the loader.
  assign unused_s = ^bus.bram_dout;

  assign bus.byte_ready_out = ready_r;
  assign bus.bram_we        = we_r;
  assign bus.bram_addr      = addr_r;
  assign bus.bram_din       = word_r;
  assign bus.bram_regce     = 1'b1;
  assign busy_out           = busy_r;
  assign done_out           = done_r;
  assign words_written_out  = ww_r;

  // Next-state decode and byte-acceptance qualification.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    last_byte_s  = (byte_idx_r == LAST_IDX);
    ww_inc_s     = ww_r + CNT_ONE;
    clamp_s      = (count_in > ADDRS_W) ? ADDRS_W : count_in;
    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          if (count_in == '0) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        accept_s = bus.byte_valid_in;
        if (accept_s && last_byte_s) begin
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (ww_inc_s >= count_r) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Outputs registered from the next state so they line up with the state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_LOAD);
      we_r    <= (next_state_s == ST_WRITE);
      busy_r  <= (next_state_s == ST_LOAD) || (next_state_s == ST_WRITE);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Datapath: capture the count, assemble words and advance the address.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_r    <= '0;
      ww_r       <= '0;
      addr_r     <= '0;
      byte_idx_r <= '0;
      word_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_in) begin
            count_r    <= clamp_s;
            ww_r       <= '0;
            addr_r     <= '0;
            byte_idx_r <= '0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            for (int k = 0; k < BYTES; k++) begin
              if (byte_idx_r == IDX_W'(k)) begin
                word_r[8*k +: 8] <= bus.byte_in;
              end
            end
            byte_idx_r <= last_byte_s ? '0 : (byte_idx_r + IDX_ONE);
          end
        end
        ST_WRITE: begin
          ww_r <= ww_inc_s;
          // The address holds at the last word so it never leaves 0..ADDRS-1.
          if (ww_inc_s < count_r) begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [OP_SIZE-1:0] checksum_r;

  assign checksum_out = checksum_r;

  // Running XOR of written words, cleared when a new load starts.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      checksum_r <= '0;
    end else if (state_r == ST_IDLE && start_in) begin
      checksum_r <= '0;
    end else if (state_r == ST_WRITE) begin
      checksum_r <= checksum_r ^ word_r;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised self-checking bench for instruction_loader (ADDRS=16, OP_SIZE=16).
module tb_instruction_loader;
  localparam int ADDRS   = 16;
  localparam int OP_SIZE = 16;
  localparam int BYTES   = OP_SIZE / 8;
  localparam int CW      = $clog2(ADDRS) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [CW-1:0] count_in;
  logic          busy_out;
  logic          done_out;
  logic [CW-1:0] words_written_out;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [OP_SIZE-1:0] checksum_out;
`endif

  instruction_loader_if #(.ADDRS(ADDRS), .OP_SIZE(OP_SIZE)) bus ();

  instruction_loader #(.ADDRS(ADDRS), .OP_SIZE(OP_SIZE)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start_in),
    .count_in          (count_in),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .words_written_out (words_written_out),
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    .checksum_out      (checksum_out),
`endif
    .bus               (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Monitor state
  int                 cyc = 0;
  int                 wr_addr_q[$];
  logic [OP_SIZE-1:0] wr_data_q[$];
  int                 wr_cyc_q[$];
  int                 done_cnt = 0;
  int                 done_cyc = 0;
  logic [CW-1:0]      done_ww;
  logic [OP_SIZE-1:0] done_chk;
  int                 viol_cnt = 0;

  // Stimulus state
  logic [7:0] tx_q[$];
  int         last_acc;
  int         start_cyc;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (bus.bram_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.bram_addr));
      wr_data_q.push_back(bus.bram_din);
      wr_cyc_q.push_back(cyc);
      if (bus.byte_ready_out !== 1'b0 || busy_out !== 1'b1) viol_cnt <= viol_cnt + 1;
    end
    if (done_out === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_ww  <= words_written_out;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      done_chk <= checksum_out;
`else
      done_chk <= '0;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, required completion");
    $fatal(1);
  end

  function automatic int model_words(input int c);
    return (c > ADDRS) ? ADDRS : c;
  endfunction

  function automatic logic [OP_SIZE-1:0] model_word(input int i);
    logic [OP_SIZE-1:0] w;
    w = '0;
    for (int k = 0; k < BYTES; k++) w = w | (OP_SIZE'(tx_q[i*BYTES+k]) << (8*k));
    return w;
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic fill_tx(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic do_start(input int c);
    @(negedge clk_in);
    bus.byte_valid_in = 1'b0;
    start_in  = 1'b1;
    count_in  = CW'(c);
    start_cyc = cyc;
    @(negedge clk_in);
    start_in = 1'b0;
    count_in = CW'($urandom);
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random gaps.
  task automatic send_bytes(input int n, input int mode, input bit noise);
    int idx = 0;
    int guard = 0;
    bit v;
    bit tog = 1'b1;
    while (idx < n && guard < 4000) begin
      @(negedge clk_in);
      guard++;
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.byte_valid_in = v;
      bus.byte_in = v ? tx_q[idx] : 8'($urandom);
      if (noise) begin
        start_in = 1'($urandom_range(0, 1));
        count_in = CW'($urandom);
      end
      if (v && bus.byte_ready_out === 1'b1) begin
        idx++;
        last_acc = cyc;
      end
    end
    @(negedge clk_in);
    bus.byte_valid_in = 1'b0;
    start_in = 1'b0;
    total++;
    if (idx !== n) begin
      bad++;
      $display("FAIL byte_accept_timeout: accepted %0d bytes, required %0d", idx, n);
    end
  endtask

  task automatic wait_done(input int base, input string name);
    int g = 0;
    while (done_cnt == base && g < 200) begin
      @(negedge clk_in);
      g++;
    end
    repeat (2) @(negedge clk_in);
    total++;
    if (done_cnt !== base + 1) begin
      bad++;
      $display("FAIL %s_done_pulses: got %0d, required %0d", name, done_cnt - base, 1);
    end
  endtask

  task automatic check_load(input string name, input int nw);
    logic [OP_SIZE-1:0] x;
    x = '0;
    total++;
    if (wr_addr_q.size() !== nw) begin
      bad++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, wr_addr_q.size(), nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        total++;
        if (wr_addr_q[i] !== i || wr_data_q[i] !== model_word(i)) begin
          bad++;
          $display("FAIL %s_word%0d: got %h@%0d, required %h@%0d",
                   name, i, wr_data_q[i], wr_addr_q[i], model_word(i), i);
        end
        x = x ^ model_word(i);
      end
      if (nw > 0) begin
        total++;
        if (wr_cyc_q[nw-1] !== last_acc + 1) begin
          bad++;
          $display("FAIL %s_we_latency: got cycle %0d, required %0d", name, wr_cyc_q[nw-1], last_acc + 1);
        end
        total++;
        if (done_cyc !== last_acc + 2) begin
          bad++;
          $display("FAIL %s_done_latency: got cycle %0d, required %0d", name, done_cyc, last_acc + 2);
        end
      end
    end
    total++;
    if (done_ww !== CW'(nw)) begin
      bad++;
      $display("FAIL %s_words_written: got %0d, required %0d", name, done_ww, nw);
    end
    total++;
    if (viol_cnt !== 0) begin
      bad++;
      $display("FAIL %s_write_cycle_ready: got %0d bad write cycles, required 0", name, viol_cnt);
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    total++;
    if (done_chk !== x) begin
      bad++;
      $display("FAIL %s_checksum: got %h, required %h", name, done_chk, x);
    end
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (bus.byte_ready_out !== 1'b0) begin bad++; $display("FAIL %s_ready: got %b, required 0", name, bus.byte_ready_out); end
    total++;
    if (busy_out !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b, required 0", name, busy_out); end
    total++;
    if (done_out !== 1'b0) begin bad++; $display("FAIL %s_done: got %b, required 0", name, done_out); end
    total++;
    if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL %s_we: got %b, required 0", name, bus.bram_we); end
    total++;
    if (bus.bram_addr !== '0) begin bad++; $display("FAIL %s_addr: got %h, required 0", name, bus.bram_addr); end
    total++;
    if (bus.bram_din !== '0) begin bad++; $display("FAIL %s_din: got %h, required 0", name, bus.bram_din); end
    total++;
    if (words_written_out !== '0) begin bad++; $display("FAIL %s_ww: got %0d, required 0", name, words_written_out); end
    total++;
    if (bus.bram_regce !== 1'b1) begin bad++; $display("FAIL %s_regce: got %b, required 1", name, bus.bram_regce); end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    start_in = 1'b0;
    count_in = '0;
    bus.byte_in = '0;
    bus.byte_valid_in = 1'b0;
    bus.bram_dout = OP_SIZE'($urandom);
    repeat (3) @(negedge clk_in);
    check_idle_outputs("reset");
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    int base;
    tx_q.delete();
    tx_q.push_back(8'h34); tx_q.push_back(8'h12);
    tx_q.push_back(8'h78); tx_q.push_back(8'h56);
    clear_mon();
    base = done_cnt;
    do_start(2);
    send_bytes(4, 0, 1'b0);
    wait_done(base, "basic");
    check_load("basic", 2);
    total++;
    if (wr_data_q.size() != 2 || wr_data_q[0] !== 16'h1234 || wr_data_q[1] !== 16'h5678) begin
      bad++;
      $display("FAIL basic_known_words: got %0d words, required 1234 and 5678", wr_data_q.size());
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    total++;
    if (done_chk !== 16'h444C) begin
      bad++;
      $display("FAIL basic_checksum_const: got %h, required 444c", done_chk);
    end
`endif
  endtask

  task automatic test_zero_count();
    int base;
    clear_mon();
    base = done_cnt;
    do_start(0);
    wait_done(base, "zero");
    total++;
    if (done_cyc !== start_cyc + 1) begin
      bad++;
      $display("FAIL zero_done_latency: got cycle %0d, required %0d", done_cyc, start_cyc + 1);
    end
    tx_q.delete();
    check_load("zero", 0);
  endtask

  task automatic test_clamp();
    int base;
    int nw;
    nw = model_words(20);
    fill_tx(nw * BYTES);
    clear_mon();
    base = done_cnt;
    do_start(20);
    send_bytes(nw * BYTES, 0, 1'b0);
    wait_done(base, "clamp");
    check_load("clamp", nw);
  endtask

  task automatic test_throttled();
    int base;
    fill_tx(4 * BYTES);
    clear_mon();
    base = done_cnt;
    do_start(4);
    send_bytes(4 * BYTES, 1, 1'b0);
    wait_done(base, "throttled");
    check_load("throttled", 4);
  endtask

  task automatic test_reset_mid_load();
    int base;
    fill_tx(2 * BYTES);
    clear_mon();
    do_start(2);
    send_bytes(BYTES + 1, 0, 1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_idle_outputs("midreset");
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    total++;
    if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 0) begin
      bad++;
      $display("FAIL midreset_writes: got %0d writes, required 1 write at address 0", wr_addr_q.size());
    end
    fill_tx(BYTES);
    clear_mon();
    base = done_cnt;
    do_start(1);
    send_bytes(BYTES, 2, 1'b0);
    wait_done(base, "afterreset");
    check_load("afterreset", 1);
  endtask

  task automatic test_random();
    int base;
    int c;
    int nw;
    for (int it = 0; it < 8; it++) begin
      c = $urandom_range(1, 20);
      nw = model_words(c);
      fill_tx(nw * BYTES);
      clear_mon();
      // Valid bytes offered while idle must not be consumed.
      repeat (2) begin
        @(negedge clk_in);
        bus.byte_valid_in = 1'b1;
        bus.byte_in = 8'($urandom);
      end
      base = done_cnt;
      do_start(c);
      send_bytes(nw * BYTES, 2, 1'b1);
      wait_done(base, "random");
      check_load("random", nw);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_clamp();
    test_throttled();
    test_reset_mid_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
